q2_panel_ctrl: RTL and testbench

- Parametrised front-panel and run controller for Q2-family cores.
- Replaces the ad-hoc start/stop/halt latch and the raw deposit/incp switch wiring with one synchronous block.
- Debounces the panel buttons and sequences deposit, address load and P increment.
- Gates core execution in three modes: run, single-step and breakpoint.
- Sits between the panel switches/buttons and the core's control unit and memory.

---
 rtl/q2_panel_ctrl_if.sv | 24 ++
 rtl/q2_panel_ctrl.sv | 172 +++++++++++++++++
 tb/tb_q2_panel_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q2_panel_ctrl_if.sv
// Core/memory side of the Q2 front-panel controller: P exchange, run gating and deposit writes.
interface q2_panel_ctrl_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] pc;
    logic             insn_done;
    logic             halt_det;
    logic             cpu_en;
    logic             pc_load;
    logic [WIDTH-1:0] pc_val;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    modport master (
        input  pc, insn_done, halt_det,
        output cpu_en, pc_load, pc_val, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output pc, insn_done, halt_det,
        input  cpu_en, pc_load, pc_val, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/q2_panel_ctrl.sv
// Q2 front-panel and run controller: debounced buttons, deposit/incp/load
// sequencing and run/step/breakpoint gating of the core.
module q2_panel_ctrl #(
    parameter int WIDTH    = 12,
    parameter int DEBOUNCE = 16,
    parameter int HAS_BKPT = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [WIDTH-1:0]     nsw,
    input  logic                 nstart_sw,
    input  logic                 nstop_sw,
    input  logic                 nstep_sw,
    input  logic                 ndep_sw,
    input  logic                 nincp_sw,
    input  logic                 nload_sw,
    input  logic                 nbrk_sw,
    q2_panel_ctrl_if.master      bus,
    output logic                 run,
    output logic                 halted,
    output logic                 bkpt_hit
);
    localparam int NBTN = 7;
    localparam int CW   = $clog2(DEBOUNCE);

    typedef enum logic [2:0] {
        ST_STOPPED, ST_RUNNING, ST_STEPPING, ST_STOPPING, ST_DEP_WR, ST_DEP_INC
    } state_t;

    state_t            state_q, state_d;
    logic [NBTN-1:0]   btn_n;
    logic [NBTN-1:0]   sync_p0, sync_p1, filt;
    logic [CW-1:0]     cnt [NBTN];
    logic [NBTN-1:0]   press, sel;
    logic [WIDTH-1:0]  sw, pc_val, mem_wdata, bkpt;
    logic              bkpt_en, pc_load;
    logic              do_start, do_dep, do_incp, do_load, do_brk, stop_halt, stop_bkpt;

    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
        return v + 1'b1;
    endfunction

    // Bit order doubles as priority: lowest index wins.
    assign btn_n = {nbrk_sw, nload_sw, nincp_sw, ndep_sw, nstep_sw, nstart_sw, nstop_sw};
    assign sw    = ~nsw;
    assign sel   = press & (~press + 7'd1);

    // Stage p0/p1: synchroniser, then per-button stability counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
            filt    <= '1;
            press   <= '0;
            cnt     <= '{default: '0};
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
            press   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_p1[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                    filt[i]  <= sync_p1[i];
                    cnt[i]   <= '0;
                    press[i] <= ~sync_p1[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        do_start  = 1'b0;
        do_dep    = 1'b0;
        do_incp   = 1'b0;
        do_load   = 1'b0;
        do_brk    = 1'b0;
        stop_halt = 1'b0;
        stop_bkpt = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                if (sel[1]) begin
                    state_d  = ST_RUNNING;
                    do_start = 1'b1;
                end else if (sel[2]) begin
                    state_d = ST_STEPPING;
                end else if (sel[3]) begin
                    state_d = ST_DEP_WR;
                    do_dep  = 1'b1;
                end else if (sel[4]) begin
                    do_incp = 1'b1;
                end else if (sel[5]) begin
                    do_load = 1'b1;
                end else if (sel[6]) begin
                    do_brk = (HAS_BKPT != 0);
                end
            end
            ST_RUNNING: begin
                if (bus.halt_det) begin
                    state_d   = ST_STOPPED;
                    stop_halt = 1'b1;
                end else if (bus.insn_done && bkpt_en && bus.pc == bkpt) begin
                    state_d   = ST_STOPPED;
                    stop_bkpt = 1'b1;
                end else if (sel[0]) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING, ST_STEPPING: begin
                if (bus.halt_det) begin
                    state_d   = ST_STOPPED;
                    stop_halt = 1'b1;
                end else if (bus.insn_done) begin
                    state_d = ST_STOPPED;
                end
            end
            ST_DEP_WR:  state_d = ST_DEP_INC;
            ST_DEP_INC: state_d = ST_STOPPED;
            default:    state_d = ST_STOPPED;
        endcase
    end

    // Stage p2: state, panel registers and strobes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_STOPPED;
            pc_val    <= '0;
            mem_wdata <= '0;
            bkpt      <= '0;
            bkpt_en   <= 1'b0;
            halted    <= 1'b0;
            bkpt_hit  <= 1'b0;
            pc_load   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_load <= 1'b0;
            if (do_start) begin
                halted   <= 1'b0;
                bkpt_hit <= 1'b0;
            end
            if (stop_halt) halted   <= 1'b1;
            if (stop_bkpt) bkpt_hit <= 1'b1;
            if (do_dep)    mem_wdata <= sw;
            // Tracking pauses while a strobe is out so the core's stale P cannot clobber it.
            if (do_load) begin
                pc_val  <= sw;
                pc_load <= 1'b1;
            end else if (do_incp || state_q == ST_DEP_INC) begin
                pc_val  <= wrap_inc(pc_val);
                pc_load <= 1'b1;
            end else if (state_q == ST_STOPPED && !pc_load) begin
                pc_val <= bus.pc;
            end
            if (do_brk) begin
                bkpt    <= sw;
                bkpt_en <= |sw;
            end
        end
    end

    assign bus.cpu_en    = (state_q == ST_RUNNING) || (state_q == ST_STOPPING) ||
                           (state_q == ST_STEPPING);
    assign run           = (state_q == ST_RUNNING) || (state_q == ST_STOPPING);
    assign bus.mem_we    = (state_q == ST_DEP_WR);
    assign bus.pc_load   = pc_load;
    assign bus.pc_val    = pc_val;
    assign bus.mem_addr  = pc_val;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_q2_panel_ctrl.sv
// Scoreboard bench for q2_panel_ctrl: panel presses, deposits, run/halt/breakpoint/step.
module tb_q2_panel_ctrl;
    localparam int WIDTH    = 12;
    localparam int DEBOUNCE = 4;
    localparam int HOLD     = DEBOUNCE + 8;
    localparam int SETTLE   = DEBOUNCE + 6;
    localparam logic [6:0] B_STOP  = 7'b0000001;
    localparam logic [6:0] B_START = 7'b0000010;
    localparam logic [6:0] B_STEP  = 7'b0000100;
    localparam logic [6:0] B_DEP   = 7'b0001000;
    localparam logic [6:0] B_INCP  = 7'b0010000;
    localparam logic [6:0] B_LOAD  = 7'b0100000;
    localparam logic [6:0] B_BRK   = 7'b1000000;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [WIDTH-1:0] nsw = '1;
    logic [6:0]       nbtn = '1;
    logic [WIDTH-1:0] core_pc = '0;
    logic [WIDTH-1:0] force_val = '0;
    logic             force_pc = 1'b0;
    logic             insn_done = 1'b0;
    logic             halt_det = 1'b0;
    logic             run, halted, bkpt_hit, run2, halted2, bkpt_hit2;

    int  n_chk = 0;
    int  n_pass = 0;
    int  wr_cnt = 0;
    int  we_len = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    q2_panel_ctrl_if #(.WIDTH(WIDTH)) bus ();
    q2_panel_ctrl_if #(.WIDTH(WIDTH)) bus2 ();

    assign bus.pc         = core_pc;
    assign bus.insn_done  = insn_done;
    assign bus.halt_det   = halt_det;
    assign bus2.pc        = core_pc;
    assign bus2.insn_done = insn_done;
    assign bus2.halt_det  = halt_det;

    q2_panel_ctrl #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .HAS_BKPT(1)) dut (
        .clk(clk), .nrst(nrst), .nsw(nsw),
        .nstart_sw(nbtn[1]), .nstop_sw(nbtn[0]), .nstep_sw(nbtn[2]), .ndep_sw(nbtn[3]),
        .nincp_sw(nbtn[4]), .nload_sw(nbtn[5]), .nbrk_sw(nbtn[6]),
        .bus(bus), .run(run), .halted(halted), .bkpt_hit(bkpt_hit)
    );

    q2_panel_ctrl #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .HAS_BKPT(0)) dut_nobk (
        .clk(clk), .nrst(nrst), .nsw(nsw),
        .nstart_sw(nbtn[1]), .nstop_sw(nbtn[0]), .nstep_sw(nbtn[2]), .ndep_sw(nbtn[3]),
        .nincp_sw(nbtn[4]), .nload_sw(nbtn[5]), .nbrk_sw(nbtn[6]),
        .bus(bus2), .run(run2), .halted(halted2), .bkpt_hit(bkpt_hit2)
    );

    // Core model: P follows panel loads, otherwise the bench can set it.
    always @(posedge clk) begin
        if (bus.pc_load) core_pc <= bus.pc_val;
        else if (force_pc) core_pc <= force_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (we_len == 0) begin
                wr_cnt <= wr_cnt + 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    chk("wr_addr", bus.mem_addr, exp_q[0].addr);
                    chk("wr_data", bus.mem_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            we_len <= we_len + 1;
        end else if (we_len != 0) begin
            chk("we_len", we_len, 1);
            we_len <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [6:0] mask, input logic [WIDTH-1:0] val);
        nsw  = ~val;
        nbtn = ~mask;
        tick(HOLD);
        nbtn = '1;
        tick(SETTLE);
    endtask

    task automatic pulse_done();
        insn_done = 1'b1;
        tick(1);
        insn_done = 1'b0;
    endtask

    task automatic pulse_halt();
        halt_det = 1'b1;
        tick(1);
        halt_det = 1'b0;
    endtask

    task automatic set_pc(input logic [WIDTH-1:0] v);
        force_val = v;
        force_pc  = 1'b1;
        tick(1);
        force_pc  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_en"}, bus.cpu_en, 0);
        chk({tag, "_run"}, run, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_bkpt_hit"}, bkpt_hit, 0);
        chk({tag, "_pc_load"}, bus.pc_load, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_pc_val"}, bus.pc_val, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, npl, nen;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] dep_data [3];
        dep_data = '{12'h0A1, 12'h0B2, 12'hFFF};

        tick(3);
        chk_reset_outputs("rst");
        nrst = 1'b1;
        tick(2);

        // Load address: latency from button edge to strobe, single strobe.
        nsw  = ~12'h100;
        nbtn = ~B_LOAD;
        lat  = 0;
        npl  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (bus.pc_load) begin
                npl++;
                if (lat == 0) lat = i;
            end
        end
        chk("load_latency", lat, DEBOUNCE + 3);
        chk("load_pulses", npl, 1);
        chk("load_pc_val", bus.pc_val, 12'h100);
        nbtn = '1;
        tick(SETTLE);

        // Glitch one sample short of the debounce window.
        nbtn = ~B_DEP;
        tick(DEBOUNCE - 1);
        nbtn = '1;
        tick(15);
        chk("glitch_wr_cnt", wr_cnt, 0);
        chk("glitch_cpu_en", bus.cpu_en, 0);

        // Increment P.
        press(B_INCP, 12'h0);
        chk("incp_pc_val", bus.pc_val, 12'h101);

        // Three deposits across the address wrap.
        press(B_LOAD, 12'hFFE);
        chk("dep_base", bus.pc_val, 12'hFFE);
        addr = 12'hFFE;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{addr: addr, data: dep_data[k]});
            addr = addr + 1'b1;
            press(B_DEP, dep_data[k]);
        end
        chk("dep_wr_cnt", wr_cnt, 3);
        chk("dep_q_empty", exp_q.size(), 0);
        chk("dep_wrap_pc", bus.pc_val, 12'h001);

        // Run, then halt_det.
        press(B_START, 12'h0);
        chk("run_cpu_en", bus.cpu_en, 1);
        chk("run_lamp", run, 1);
        tick(5);
        halt_det = 1'b1;
        chk("halt_pre_cpu_en", bus.cpu_en, 1);
        tick(1);
        halt_det = 1'b0;
        chk("halt_cpu_en", bus.cpu_en, 0);
        chk("halt_run", run, 0);
        chk("halt_halted", halted, 1);
        press(B_START, 12'h0);
        chk("restart_halted", halted, 0);
        chk("restart_cpu_en", bus.cpu_en, 1);

        // Stop waits for the instruction to finish.
        press(B_STOP, 12'h0);
        chk("stopping_run", run, 1);
        nen = 0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (bus.cpu_en) nen++;
        end
        chk("stopping_hold", nen, 7);
        pulse_done();
        chk("stopped_cpu_en", bus.cpu_en, 0);
        chk("stopped_run", run, 0);
        chk("stopped_halted", halted, 0);

        // Breakpoint at 020; second instance has no breakpoint logic.
        press(B_BRK, 12'h020);
        press(B_START, 12'h0);
        set_pc(12'h010);
        pulse_done();
        chk("bkpt_miss_run", run, 1);
        set_pc(12'h020);
        pulse_done();
        chk("bkpt_run", run, 0);
        chk("bkpt_cpu_en", bus.cpu_en, 0);
        chk("bkpt_hit", bkpt_hit, 1);
        chk("bkpt_halted", halted, 0);
        chk("nobk_run", run2, 1);
        chk("nobk_bkpt_hit", bkpt_hit2, 0);

        // halt_det and breakpoint in the same cycle: halt wins.
        press(B_START, 12'h0);
        chk("restart_bkpt_hit", bkpt_hit, 0);
        insn_done = 1'b1;
        halt_det  = 1'b1;
        tick(1);
        insn_done = 1'b0;
        halt_det  = 1'b0;
        chk("both_halted", halted, 1);
        chk("both_bkpt_hit", bkpt_hit, 0);
        chk("nobk_halted", halted2, 1);
        chk("nobk_stopped", run2, 0);

        // Breakpoint cleared with all switches released.
        press(B_BRK, 12'h0);
        press(B_START, 12'h0);
        pulse_done();
        chk("bkpt_clr_run", run, 1);
        pulse_halt();
        chk("bkpt_clr_stop", run, 0);

        // Single step.
        press(B_STEP, 12'h0);
        chk("step_cpu_en", bus.cpu_en, 1);
        chk("step_run", run, 0);
        pulse_done();
        chk("step_done_cpu_en", bus.cpu_en, 0);

        // Start and deposit together: start wins, no write.
        press(B_START | B_DEP, 12'h055);
        chk("start_dep_run", run, 1);
        chk("start_dep_wr_cnt", wr_cnt, 3);
        pulse_halt();
        chk("start_dep_stop", run, 0);

        // Reset while the deposit write is on the bus.
        nsw  = ~12'h0AA;
        nbtn = ~B_DEP;
        repeat (DEBOUNCE + 3) @(posedge clk);
        #1;
        chk("dep_wr_reached", bus.mem_we, 1);
        nrst = 1'b0;
        @(negedge clk);
        nbtn = '1;
        chk_reset_outputs("rst_dep");
        tick(2);
        nrst = 1'b1;
        tick(SETTLE);
        chk("rst_dep_wr_cnt", wr_cnt, 3);
        chk("rst_dep_state", bus.cpu_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
